// File: rtl/align_result_if.sv
// rtl/align_result_if.sv - traceback step input and frame byte output handshakes for align_result_tx
interface align_result_if #(
  parameter int OUT_WIDTH = 8
) ();
  logic                 tb_valid;
  logic [1:0]           tb_dir;
  logic                 tb_last;
  logic                 tb_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output tb_valid, tb_dir, tb_last, out_ready,
    input  tb_ready, out_data, out_valid
  );

  modport slave (
    input  tb_valid, tb_dir, tb_last, out_ready,
    output tb_ready, out_data, out_valid
  );
endinterface

// File: rtl/align_result_tx.sv
// rtl/align_result_tx.sv - frames winning cell and traceback directions into bytes
// Optional trailing XOR check byte when ALIGN_TX_CHECKSUM_EN is defined.
module align_result_tx #(
  parameter int OUT_WIDTH   = 8,
  parameter int SEQ_LENGTH  = 32,
  parameter int SCORE_WIDTH = 7,
  parameter int POS_W       = 5,
  parameter int CNT_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SCORE_WIDTH-1:0] max_score,
  input  logic [POS_W-1:0]       max_row,
  input  logic [POS_W-1:0]       max_col,
  align_result_if.slave          bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int MAX_STEPS = 2 * SEQ_LENGTH - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_SCORE, S_ROW, S_COL, S_DIRS, S_FLUSH, S_TRAIL
`ifdef ALIGN_TX_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t                 state, state_n;
  logic [OUT_WIDTH-1:0]   out_data, out_data_n;
  logic                   out_valid, out_valid_n;
  logic [5:0]             acc, acc_n;
  logic [1:0]             acc_cnt, acc_cnt_n;
  logic [CNT_W-1:0]       step_cnt, step_cnt_n;
  logic                   trail_loaded, trail_loaded_n;
  logic                   overflow_n, done_n;
  logic [SCORE_WIDTH-1:0] score_q, score_n;
  logic [POS_W-1:0]       row_q, row_n, col_q, col_n;
  logic                   handshake, slot_free;
  logic [1:0]             dir_enc;
`ifdef ALIGN_TX_CHECKSUM_EN
  logic [OUT_WIDTH-1:0]   chk_q;
  logic                   byte_load;
`endif

  assign handshake     = out_valid && bus.out_ready;
  assign slot_free     = !out_valid || bus.out_ready;
  assign dir_enc       = (bus.tb_dir == 2'b10) ? 2'b00 : bus.tb_dir;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      out_data     <= '0;
      out_valid    <= 1'b0;
      acc          <= '0;
      acc_cnt      <= '0;
      step_cnt     <= '0;
      trail_loaded <= 1'b0;
      overflow     <= 1'b0;
      done         <= 1'b0;
      score_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
    end else begin
      state        <= state_n;
      out_data     <= out_data_n;
      out_valid    <= out_valid_n;
      acc          <= acc_n;
      acc_cnt      <= acc_cnt_n;
      step_cnt     <= step_cnt_n;
      trail_loaded <= trail_loaded_n;
      overflow     <= overflow_n;
      done         <= done_n;
      score_q      <= score_n;
      row_q        <= row_n;
      col_q        <= col_n;
    end
  end

  always_comb begin
    state_n        = state;
    out_data_n     = out_data;
    out_valid_n    = out_valid;
    acc_n          = acc;
    acc_cnt_n      = acc_cnt;
    step_cnt_n     = step_cnt;
    trail_loaded_n = trail_loaded;
    overflow_n     = overflow;
    done_n         = 1'b0;
    score_n        = score_q;
    row_n          = row_q;
    col_n          = col_q;
    bus.tb_ready   = 1'b0;
    // A consumed byte empties the slot unless a state below reloads it.
    if (handshake) out_valid_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          score_n        = max_score;
          row_n          = max_row;
          col_n          = max_col;
          overflow_n     = 1'b0;
          step_cnt_n     = '0;
          acc_n          = '0;
          acc_cnt_n      = '0;
          trail_loaded_n = 1'b0;
          out_data_n     = OUT_WIDTH'(8'hE0);
          out_valid_n    = 1'b1;
          state_n        = S_HDR;
        end
      end
      S_HDR: begin
        if (handshake) begin
          out_data_n  = OUT_WIDTH'({1'b0, score_q});
          out_valid_n = 1'b1;
          state_n     = S_SCORE;
        end
      end
      S_SCORE: begin
        if (handshake) begin
          out_data_n  = OUT_WIDTH'(row_q);
          out_valid_n = 1'b1;
          state_n     = S_ROW;
        end
      end
      S_ROW: begin
        if (handshake) begin
          out_data_n  = OUT_WIDTH'(col_q);
          out_valid_n = 1'b1;
          state_n     = S_COL;
        end
      end
      S_COL: begin
        if (handshake) state_n = S_DIRS;
      end
      S_DIRS: begin
        // Slots 0..2 need no output space; the 4th step completes a byte.
        bus.tb_ready = (acc_cnt != 2'd3) || slot_free;
        if (bus.tb_valid && bus.tb_ready) begin
          if (step_cnt == CNT_W'(MAX_STEPS)) begin
            overflow_n = 1'b1;
          end else begin
            step_cnt_n = step_cnt + 1'b1;
            if (acc_cnt == 2'd3) begin
              out_data_n  = OUT_WIDTH'({dir_enc, acc});
              out_valid_n = 1'b1;
              acc_n       = '0;
              acc_cnt_n   = '0;
            end else begin
              acc_n[{acc_cnt, 1'b0} +: 2] = dir_enc;
              acc_cnt_n                   = acc_cnt + 2'd1;
            end
          end
          if (bus.tb_last) state_n = (acc_cnt_n == 2'd0) ? S_TRAIL : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (slot_free) begin
          out_data_n  = OUT_WIDTH'({2'b00, acc});
          out_valid_n = 1'b1;
          acc_n       = '0;
          acc_cnt_n   = '0;
          state_n     = S_TRAIL;
        end
      end
      S_TRAIL: begin
        // The last direction byte may still occupy the slot on entry.
        if (!trail_loaded) begin
          if (slot_free) begin
            out_data_n     = OUT_WIDTH'({2'b11, step_cnt});
            out_valid_n    = 1'b1;
            trail_loaded_n = 1'b1;
          end
        end else if (handshake) begin
`ifdef ALIGN_TX_CHECKSUM_EN
          out_data_n  = chk_q;
          out_valid_n = 1'b1;
          state_n     = S_CHK;
`else
          done_n  = 1'b1;
          state_n = S_IDLE;
`endif
        end
      end
`ifdef ALIGN_TX_CHECKSUM_EN
      S_CHK: begin
        if (handshake) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

`ifdef ALIGN_TX_CHECKSUM_EN
  // Running XOR of every byte placed in the output register; the header restarts it.
  assign byte_load = out_valid_n && (!out_valid || handshake);

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else if (byte_load) begin
      chk_q <= (state == S_IDLE) ? out_data_n : (chk_q ^ out_data_n);
    end
  end
`endif

endmodule

// File: tb/tb_align_result_tx.sv
// tb/tb_align_result_tx.sv - self-checking bench for align_result_tx (vectors, corner sequences, random frames)
module tb_align_result_tx;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [6:0] max_score;
  logic [4:0] max_row, max_col;
  logic       busy, done, overflow;

  align_result_if #(.OUT_WIDTH(8)) bus ();

  align_result_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .max_score(max_score), .max_row(max_row), .max_col(max_col),
    .bus(bus), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

`ifdef ALIGN_TX_CHECKSUM_EN
  localparam int TAILIDX = 2;
`else
  localparam int TAILIDX = 1;
`endif

  int total = 0, bad = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -10, last_hs = -10;
  int ready_mode = 0, pcnt = 0;
  logic [7:0] got[$], exp_q[$];
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;

  typedef struct packed {
    logic [6:0]  s;
    logic [4:0]  r;
    logic [4:0]  c;
    int          n;
    logic [15:0] dirs;
    int          mode;
    int          nexp;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input bit ok, input string name, input longint act, input longint want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    bit [3:0] pat;
    pat = 4'b1001;
    #1;
    case (ready_mode)
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      2:       bus.out_ready = pat[3 - (pcnt % 4)];
      default: bus.out_ready = 1'b1;
    endcase
    pcnt++;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst && cyc > 3) begin
      if (prev_stall)
        check(bus.out_valid === 1'b1 && bus.out_data === prev_data, "hold_while_stalled", bus.out_data, prev_data);
      if (busy === 1'b0)
        check(bus.tb_ready === 1'b0, "tb_ready_when_idle", bus.tb_ready, 0);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got.push_back(bus.out_data);
        last_hs = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_stall = !rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b0;
    prev_data  = bus.out_data;
  end

  // Reference frame from the byte-format rules: header, cell, 4 steps/byte, trailer.
  task automatic model(input logic [6:0] s, input logic [4:0] r, input logic [4:0] c, input logic [1:0] d[$]);
    int n;
    logic [7:0] b;
    n = (d.size() > 63) ? 63 : d.size();
    exp_q.delete();
    exp_q.push_back(8'hE0);
    exp_q.push_back({1'b0, s});
    exp_q.push_back({3'b000, r});
    exp_q.push_back({3'b000, c});
    for (int i = 0; i < n; i += 4) begin
      b = 8'h00;
      for (int k = 0; k < 4; k++)
        if (i + k < n) b[2*k +: 2] = (d[i+k] == 2'b10) ? 2'b00 : d[i+k];
      exp_q.push_back(b);
    end
    exp_q.push_back({2'b11, 6'(n)});
  endtask

  task automatic run_frame(input logic [6:0] s, input logic [4:0] r, input logic [4:0] c,
                           input logic [1:0] d[$], input int mode);
    int guard;
    ready_mode = mode;
    pcnt       = 0;
    got.delete();
    done_cnt = 0; done_cyc = -10; last_hs = -10;
    max_score = s; max_row = r; max_col = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < d.size(); i++) begin
      bus.tb_valid = 1'b1;
      bus.tb_dir   = d[i];
      bus.tb_last  = (i == d.size() - 1);
      guard = 0;
      @(negedge clk);
      while (bus.tb_ready !== 1'b1 && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) begin
        check(1'b0, "step_accept_timeout", i, 0);
        break;
      end
      tick();
    end
    bus.tb_valid = 1'b0;
    bus.tb_last  = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin
      tick();
      guard++;
    end
    if (done_cnt == 0) check(1'b0, "done_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic compare_frame(input string name, input bit want_ovf);
`ifdef ALIGN_TX_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
    check(got.size() == exp_q.size(), {name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size())
        check(got[i] === exp_q[i], $sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
    end
    check(done_cnt == 1, {name, "_done_pulses"}, done_cnt, 1);
    check(done_cyc == last_hs + 1, {name, "_done_latency"}, done_cyc - last_hs, 1);
    check(overflow === want_ovf, {name, "_overflow"}, overflow, want_ovf);
  endtask

  task automatic check_tail(input string name);
    if (got.size() >= TAILIDX + 1) begin
      check(got[got.size()-TAILIDX] === 8'hFF, {name, "_trail"}, got[got.size()-TAILIDX], 8'hFF);
      check(got[got.size()-TAILIDX-1] === 8'h15, {name, "_lastdir"}, got[got.size()-TAILIDX-1], 8'h15);
    end else begin
      check(1'b0, {name, "_short"}, got.size(), TAILIDX + 1);
    end
  endtask

  initial begin
    logic [1:0] dq[$];
    int n;
    #500000;
    $display("FAIL watchdog_expired actual=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0] dq[$];
    int n;
    rst = 1'b1; start = 1'b0;
    max_score = '0; max_row = '0; max_col = '0;
    bus.tb_valid = 1'b0; bus.tb_dir = 2'b00; bus.tb_last = 1'b0;
    repeat (3) tick();
    check(bus.out_valid === 1'b0, "rst_out_valid", bus.out_valid, 0);
    check(bus.out_data === 8'h00, "rst_out_data", bus.out_data, 0);
    check(bus.tb_ready === 1'b0, "rst_tb_ready", bus.tb_ready, 0);
    check(busy === 1'b0, "rst_busy", busy, 0);
    check(done === 1'b0, "rst_done", done, 0);
    check(overflow === 1'b0, "rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{7'd20, 5'd9, 5'd11, 4, 16'h0034, 0, 6, 64'h0000_C434_0B09_14E0};
    vecs[1] = '{7'h7F, 5'd31, 5'd0, 5, 16'h01FF, 0, 7, 64'h00C5_01FF_001F_7FE0};
    vecs[2] = '{7'd20, 5'd9, 5'd11, 4, 16'h0034, 2, 6, 64'h0000_C434_0B09_14E0};
    vecs[3] = '{7'd1, 5'd2, 5'd3, 1, 16'h0003, 0, 6, 64'h0000_C103_0302_01E0};
    vecs[4] = '{7'd0, 5'd0, 5'd0, 4, 16'h00E6, 2, 6, 64'h0000_C4C4_0000_00E0};

    for (int v = 0; v < 5; v++) begin
      dq.delete();
      for (int i = 0; i < vecs[v].n; i++) dq.push_back(vecs[v].dirs[2*i +: 2]);
      run_frame(vecs[v].s, vecs[v].r, vecs[v].c, dq, vecs[v].mode);
      exp_q.delete();
      for (int i = 0; i < vecs[v].nexp; i++) exp_q.push_back(vecs[v].exp[8*i +: 8]);
      compare_frame($sformatf("vec%0d", v), 1'b0);
    end

    dq.delete();
    for (int i = 0; i < 63; i++) dq.push_back(2'b01);
    run_frame(7'd1, 5'd2, 5'd3, dq, 0);
    model(7'd1, 5'd2, 5'd3, dq);
    compare_frame("steps63", 1'b0);
    check_tail("steps63");

    dq.delete();
    for (int i = 0; i < 65; i++) dq.push_back(2'b01);
    run_frame(7'd4, 5'd5, 5'd6, dq, 1);
    model(7'd4, 5'd5, 5'd6, dq);
    compare_frame("steps65", 1'b1);
    check_tail("steps65");

    ready_mode = 0;
    max_score = 7'd5; max_row = 5'd6; max_col = 5'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.tb_valid = 1'b1; bus.tb_dir = 2'b01; bus.tb_last = 1'b0;
    repeat (8) tick();
    check(busy === 1'b1, "pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    check(bus.out_valid === 1'b0, "midrst_out_valid", bus.out_valid, 0);
    check(busy === 1'b0, "midrst_busy", busy, 0);
    check(bus.tb_ready === 1'b0, "midrst_tb_ready", bus.tb_ready, 0);
    rst = 1'b0;
    bus.tb_valid = 1'b0;
    tick();
    dq.delete();
    dq.push_back(2'b00); dq.push_back(2'b01); dq.push_back(2'b11); dq.push_back(2'b00);
    run_frame(7'd20, 5'd9, 5'd11, dq, 0);
    model(7'd20, 5'd9, 5'd11, dq);
    compare_frame("after_rst", 1'b0);

    for (int f = 0; f < 12; f++) begin
      logic [6:0] s;
      logic [4:0] r, c;
      n = (f == 3) ? 64 : $urandom_range(1, 70);
      s = 7'($urandom); r = 5'($urandom); c = 5'($urandom);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(2'($urandom_range(0, 3)));
      run_frame(s, r, c, dq, 1);
      model(s, r, c, dq);
      compare_frame($sformatf("rand%0d", f), n > 63);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/align_result_tx.md
Name: align_result_tx

Overview:
Transmit side of the alignment result path. It takes the winning cell (max score, row, col) and the per-step traceback direction stream from the traceback engine. It frames them into 8-bit bytes on a valid/ready output bus, which is the mirror of the 8-bit sequence buffer input. It sits between the traceback unit and the host interface.

Parameters:
OUT_WIDTH, 8, output byte width (matches INPUT_WIDTH)
SEQ_LENGTH, 32, sequence length; path length is at most 2*SEQ_LENGTH-1 = 63
SCORE_WIDTH, 7, max score width
POS_W, 5, row/col width ($clog2(SEQ_LENGTH))
CNT_W, 6, step counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; captures max_score/max_row/max_col
max_score  in  7  best alignment score
max_row  in  5  row of best cell
max_col  in  5  col of best cell
tb_valid  in  1  traceback step valid
tb_dir  in  2  direction: 00 diag, 01 left, 11 top (10 treated as diag)
tb_last  in  1  marks final step of path
tb_ready  out  1  step accepted when tb_valid&&tb_ready
out_data  out  8  frame byte
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts when out_valid&&out_ready
busy  out  1  frame in progress
done  out  1  one-cycle pulse after last frame byte handshakes
overflow  out  1  sticky; more than 63 steps received in current frame

Behaviour:
- Reset (sync, active-high): state=IDLE. out_data=0, out_valid=0, tb_ready=0, busy=0, done=0, overflow=0. Accumulator and counters are cleared. Reset mid-frame aborts the frame with no trailer.
- Frame byte order:
  - HDR {3'b111,5'b0} = 8'hE0
  - SCORE {1'b0,score}
  - ROW {3'b0,row}
  - COL {3'b0,col}
  - N direction bytes: 4 steps per byte, first step in [1:0], then [3:2], [5:4], [7:6]; unused slots are 00
  - TRAIL {2'b11,step_count[5:0]}
- FSM: IDLE -> HDR -> SCORE -> ROW -> COL -> DIRS -> (FLUSH) -> TRAIL -> IDLE.
- IDLE: start captures inputs. Next cycle: state=HDR, out_valid=1, out_data=8'hE0, busy=1. Latency start->first byte is 1 cycle.
- Output register rule: out_data/out_valid are registered. Once out_valid=1, out_data holds until the handshake. The next byte loads in the handshake cycle, giving back-to-back throughput of 1 byte/cycle.
- HDR/SCORE/ROW/COL: advance on handshake. tb_ready=0.
- DIRS:
  - tb_ready=1 when acc_cnt<3, or when the output slot is free (!out_valid || out_ready).
  - On accept: tb_dir goes into slot acc_cnt; acc_cnt++; step_count++ (saturates at 63; a 64th+ accept sets overflow and the step is discarded).
  - On the 4th step the byte moves to the output register in the same cycle and acc_cnt=0.
- tb_last accepted:
  - If acc_cnt==0 after the accept (exact multiple of 4): go to TRAIL.
  - Otherwise go to FLUSH, which pushes the partial byte when the slot is free, then TRAIL.
  - tb_ready=0 from the cycle after tb_last.
- TRAIL: present {2'b11,count}. On handshake: done=1 for one cycle, busy=0, state=IDLE. overflow clears on the next start.
- start while busy is ignored. start and a same-cycle handshake of the previous trailer: start is ignored (IDLE is not yet entered).
- tb_valid outside DIRS is ignored; tb_ready=0.
- Empty path: tb_last on the first step gives one dir byte, then TRAIL with count=1. Zero-step frames are not supported.
- out_valid never drops without a handshake, except on rst.

Optional Feature:
ALIGN_TX_CHECKSUM_EN: when defined, a CHK byte follows TRAIL. CHK is the XOR of all prior frame bytes (HDR through TRAIL). The added state is TRAIL -> CHK -> IDLE, and done pulses after the CHK handshake. When undefined, frames end at TRAIL and the CHK state and XOR register are absent.

Test Plan:
- start score=7'd20,row=5'd9,col=5'd11; steps 00,01,11,00 then tb_last; out_ready=1 -> bytes E0,14,09,0B,34,C4; done 1 cycle after C4 handshake.
- 5 steps (11,11,11,11,01 with tb_last), out_ready=1 -> dir bytes FF,01; TRAIL C5; FLUSH state visited once.
- Same frame as test 1 with out_ready toggled 1-0-0-1 -> out_data stable while out_valid&&!out_ready; tb_ready=0 whenever acc full and slot busy; byte stream unchanged.
- 63 steps of 01 -> 15 bytes 55 + one byte 15 (0x15), TRAIL FF, overflow=0; repeat with 65 steps -> TRAIL FF, overflow=1, excess steps dropped.
- rst asserted mid-DIRS -> next cycle out_valid=0, busy=0, tb_ready=0; new start sends fresh E0 header.
- ALIGN_TX_CHECKSUM_EN, test 1 stimulus -> extra byte 8'h06 (XOR E0^14^09^0B^34^C4) before done.
